// File: rtl/firebird7_in_gate1_ijtag_pkg.sv
// Shared IJTAG definitions for the gate1 TDR access controller.
package firebird7_in_gate1_ijtag_pkg;

  localparam int TDR_ACC_MAX_LEN = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } tdr_acc_state_e;

endpackage

// File: rtl/firebird7_in_gate1_tdr_access_ctrl.sv
// Runs one capture/shift/update access into a single IJTAG TDR segment and
// returns the bits scanned out on so as a parallel response.
module firebird7_in_gate1_tdr_access_ctrl
  import firebird7_in_gate1_ijtag_pkg::*;
#(
  parameter int MAX_LEN = TDR_ACC_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [MAX_LEN-1:0] req_wdata,
  input  logic               req_noupd,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_rdata,
  output logic               busy,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  tdr_acc_state_e     state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] wdata_q, wdata_d;
  logic [MAX_LEN-1:0] rdata_q, rdata_d;
  logic               noupd_q, noupd_d;
  logic               sel_q, sel_d, ce_q, ce_d, se_q, se_d, ue_q, ue_d, si_q, si_d;
  logic               rspValid_q, rspValid_d, busy_q, busy_d;
  logic [LEN_W-1:0]   lenClamped;
  logic [IDX_W-1:0]   cntIdx, siIdx;

  assign lenClamped = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;
  assign cntIdx     = cnt_q[IDX_W-1:0];
  assign siIdx      = cnt_d[IDX_W-1:0];

  // State, datapath and all segment controls are registered together.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      noupd_q    <= 1'b0;
      sel_q      <= 1'b0;
      ce_q       <= 1'b0;
      se_q       <= 1'b0;
      ue_q       <= 1'b0;
      si_q       <= 1'b0;
      rspValid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      noupd_q    <= noupd_d;
      sel_q      <= sel_d;
      ce_q       <= ce_d;
      se_q       <= se_d;
      ue_q       <= ue_d;
      si_q       <= si_d;
      rspValid_q <= rspValid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and datapath; cnt holds on the last shift so it stays below MAX_LEN.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    noupd_d = noupd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          len_d   = lenClamped;
          wdata_d = req_wdata;
          noupd_d = req_noupd;
          rdata_d = '0;
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (len_q == '0) state_d = noupd_q ? ST_DONE : ST_UPDATE;
        else             state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        rdata_d[cntIdx] = ijtag_so;
        if (cnt_q == len_q - LEN_ONE) state_d = noupd_q ? ST_DONE : ST_UPDATE;
        else                          cnt_d   = cnt_q + LEN_ONE;
      end
      ST_UPDATE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered controls line up with it.
  always_comb begin
    sel_d      = (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) || (state_d == ST_UPDATE);
    ce_d       = (state_d == ST_CAPTURE);
    se_d       = (state_d == ST_SHIFT);
    ue_d       = (state_d == ST_UPDATE);
    si_d       = (state_d == ST_SHIFT) ? wdata_d[siIdx] : 1'b0;
    rspValid_d = (state_d == ST_DONE);
    busy_d     = sel_d;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rdata_q;
  assign busy      = busy_q;
  assign ijtag_sel = sel_q;
  assign ijtag_ce  = ce_q;
  assign ijtag_se  = se_q;
  assign ijtag_ue  = ue_q;
  assign ijtag_si  = si_q;

endmodule

// File: doc/firebird7_in_gate1_tdr_access_ctrl.md
# firebird7_in_gate1_tdr_access_ctrl

Sequences one complete IJTAG access (capture, shift, update) into a single TDR segment, such as the 8-bit spare TDR in gate1. It accepts a parallel request carrying scan data and a bit length, then drives the segment's sel/ce/se/ue/si controls. It returns the bits shifted out on so as a parallel response. It sits between on-chip test logic or a BIST sequencer and the gate1 IJTAG network, and runs entirely on ijtag_tck.

## Interface
- MAX_LEN, default 32: maximum scan length in bits; also the width of req_wdata and rsp_rdata.
- LEN_W, default $clog2(MAX_LEN+1): width of req_len.
- ijtag_tck  in  1  sole clock; all state updates on posedge.
- ijtag_reset  in  1  reset; synchronous and active-high.
- req_valid  in  1  access request.
- req_ready  out  1  high only in IDLE.
- req_len  in  LEN_W  number of shift cycles; values above MAX_LEN are clamped to MAX_LEN.
- req_wdata  in  MAX_LEN  scan-in data, shifted LSB first.
- req_noupd  in  1  when 1, the UPDATE phase is skipped (read-only access).
- rsp_valid  out  1  one-cycle pulse when the access completes.
- rsp_rdata  out  MAX_LEN  scan-out data; bit k is the k-th bit out of so; bits at or above len are 0.
- busy  out  1  high from acceptance until rsp_valid is asserted.
- ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si  out  1 each  segment controls; all registered.
- ijtag_so  in  1  segment scan-out, already retimed on the falling edge of tck by the segment.

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, DONE.
- IDLE:
  - req_ready=1; all ijtag_* outputs are 0.
  - When req_valid & req_ready, latch the clamped length L, wdata and noupd; clear the rdata register and the bit counter; go to CAPTURE.
- CAPTURE: drive sel=1, ce=1 for one cycle.
  - If L=0, go to UPDATE, or to DONE when noupd=1.
  - Otherwise go to SHIFT.
- SHIFT: drive sel=1, se=1, and si=wdata[cnt].
  - On each posedge, sample ijtag_so into rdata[cnt], then increment cnt.
  - When cnt reaches L-1, leave SHIFT: go to UPDATE, or to DONE when noupd=1.
- UPDATE: drive sel=1, ue=1 for one cycle; then go to DONE.
- DONE: rsp_valid=1 and rsp_rdata valid for one cycle; then go to IDLE.
- ce, se and ue are mutually exclusive. sel is high in CAPTURE, SHIFT and UPDATE only.
- cnt is LEN_W bits wide and never exceeds MAX_LEN-1.
- Reset value of every output is 0 (rsp_rdata=0, ijtag_*=0, busy=0), except req_ready=1.
- Reset asserted in any state forces IDLE on the next edge and discards the access; no rsp_valid is produced.
- req_valid while not in IDLE is ignored; the request is not queued.

## Timing
- The request is accepted at edge t. CAPTURE controls are active in cycle t+1.
- SHIFT occupies cycles t+2 through t+1+L.
- UPDATE, when present, occupies cycle t+2+L.
- rsp_valid is asserted in cycle t+3+L, or t+2+L when noupd=1.
- req_ready returns high in the cycle after DONE. The minimum request spacing is therefore L+4 cycles (L+3 with noupd).
- The so sample taken on a shift edge equals the segment's bit 0 before that shift, because the segment latch is transparent while tck is low.

## Structure
- Shared package firebird7_in_gate1_ijtag_pkg holds:
  - the state enum typedef `tdr_acc_state_e`;
  - the default MAX_LEN constant.
- Single flat module; no sub-module is needed. The FSM, counter and the wdata/rdata registers are all in one block.

## Test plan
All scenarios use the 8-bit spare TDR segment as the DUT's load; that segment captures 0x00.
- Write: L=8, wdata=0xA5, noupd=0.
  - rsp_rdata=0x00; TDR holds 0xA5.
  - rsp_valid is asserted exactly 11 cycles after acceptance.
- Overshift: L=16, wdata=0x5AA5.
  - rsp_rdata=0xA500; TDR holds 0x5A.
  - The ue pulse occurs in cycle t+18.
- Zero length: L=0, noupd=0.
  - Drives exactly one ce cycle and one ue cycle, with no se.
  - rsp_rdata=0; rsp_valid is asserted at t+3.
- Clamp: L=40 with MAX_LEN=32.
  - Exactly 32 se cycles; rsp_valid at t+35.
  - A second req_valid held high during the access is ignored.
- Reset in SHIFT after 3 shifts.
  - All ijtag_* outputs are 0 on the next cycle and req_ready=1.
  - No rsp_valid pulse occurs; a following L=8 access completes normally.
- Read-only: noupd=1, L=8.
  - No ue pulse; rsp_valid is asserted at t+10.
